// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: bank of WIDTH independent flip-flops, each channel
// run-time selectable as D, T, SR or JK. Provides a global enable, a
// synchronous parallel load, per-bit change pulses and sticky illegal-SR flags.
// Optional macro ILLEGAL_CNT_EN adds a saturating illegal-event counter on
// err_cnt; without it err_cnt is tied to zero.
module multi_mode_ff_bank #(
  parameter int unsigned       WIDTH      = 8,
  parameter logic [WIDTH-1:0]  RST_VAL    = '0,
  parameter int unsigned       SR_ILL_POL = 0,
  parameter int unsigned       ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     q_n,
  output logic [WIDTH-1:0]     chg,
  output logic [WIDTH-1:0]     err_ill,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] ill_evt;

  // Per-channel next state and illegal-SR detection; load overrides everything.
  always_comb begin
    q_next  = q;
    ill_evt = '0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        unique case (mode_e'(mode[2*i +: 2]))
          MODE_D:  q_next[i] = a[i];
          MODE_T:  q_next[i] = q[i] ^ a[i];
          MODE_SR: begin
            unique case ({a[i], b[i]})
              2'b00: q_next[i] = q[i];
              2'b01: q_next[i] = 1'b0;
              2'b10: q_next[i] = 1'b1;
              2'b11: begin
                ill_evt[i] = 1'b1;
                if (SR_ILL_POL == 1)      q_next[i] = 1'b1;
                else if (SR_ILL_POL == 2) q_next[i] = 1'b0;
                else                      q_next[i] = q[i];
              end
            endcase
          end
          MODE_JK: begin
            unique case ({a[i], b[i]})
              2'b00: q_next[i] = q[i];
              2'b01: q_next[i] = 1'b0;
              2'b10: q_next[i] = 1'b1;
              2'b11: q_next[i] = ~q[i];
            endcase
          end
        endcase
      end
    end
  end

  // State, change pulses and sticky flags; a new event beats err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= RST_VAL;
      chg     <= '0;
      err_ill <= '0;
    end else begin
      q       <= q_next;
      chg     <= q_next ^ q;
      err_ill <= ill_evt | (err_ill & ~{WIDTH{err_clr}});
    end
  end

  assign q_n = ~q;

`ifdef ILLEGAL_CNT_EN
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  logic any_ill;
  assign any_ill = |ill_evt;

  // Saturating count of cycles with at least one illegal SR event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= any_ill ? CNT_ONE : '0;
    end else if (any_ill && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed testbench for multi_mode_ff_bank: three instances (SR_ILL_POL 0/1/2)
// share one stimulus stream; expectations are hand-computed constants.
module tb_multi_mode_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] mode;
  logic [3:0] a, b;
  logic       load;
  logic [3:0] load_val;
  logic       err_clr;

  logic [3:0] q0, q1, q2, qn0, qn1, qn2, c0, c1, c2, e0, e1, e2;
  logic [1:0] n0, n1, n2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_mode_ff_bank #(.WIDTH(4), .RST_VAL(4'b0101), .SR_ILL_POL(0), .ERR_CNT_W(2)) u_p0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .load(load),
    .load_val(load_val), .err_clr(err_clr), .q(q0), .q_n(qn0), .chg(c0),
    .err_ill(e0), .err_cnt(n0));

  multi_mode_ff_bank #(.WIDTH(4), .RST_VAL(4'b0101), .SR_ILL_POL(1), .ERR_CNT_W(2)) u_p1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .load(load),
    .load_val(load_val), .err_clr(err_clr), .q(q1), .q_n(qn1), .chg(c1),
    .err_ill(e1), .err_cnt(n1));

  multi_mode_ff_bank #(.WIDTH(4), .RST_VAL(4'b0101), .SR_ILL_POL(2), .ERR_CNT_W(2)) u_p2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .load(load),
    .load_val(load_val), .err_clr(err_clr), .q(q2), .q_n(qn2), .chg(c2),
    .err_ill(e2), .err_cnt(n2));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks every output of all three instances against expected values.
  task automatic expect_state(input string tag,
                              input logic [3:0] eq0, input logic [3:0] eq1, input logic [3:0] eq2,
                              input logic [3:0] ec0, input logic [3:0] ec1, input logic [3:0] ec2,
                              input logic [3:0] eill, input logic [1:0] ecnt);
    logic [3:0] cnt_exp;
`ifdef ILLEGAL_CNT_EN
    cnt_exp = {2'b00, ecnt};
`else
    cnt_exp = 4'b0000;
    if (ecnt != ecnt) cnt_exp = 4'b1111;
`endif
    chk({tag, ".q0"},   q0,  eq0);
    chk({tag, ".q1"},   q1,  eq1);
    chk({tag, ".q2"},   q2,  eq2);
    chk({tag, ".qn0"},  qn0, ~eq0);
    chk({tag, ".qn1"},  qn1, ~eq1);
    chk({tag, ".qn2"},  qn2, ~eq2);
    chk({tag, ".chg0"}, c0,  ec0);
    chk({tag, ".chg1"}, c1,  ec1);
    chk({tag, ".chg2"}, c2,  ec2);
    chk({tag, ".ill0"}, e0,  eill);
    chk({tag, ".ill1"}, e1,  eill);
    chk({tag, ".ill2"}, e2,  eill);
    chk({tag, ".cnt0"}, {2'b00, n0}, cnt_exp);
    chk({tag, ".cnt1"}, {2'b00, n1}, cnt_exp);
    chk({tag, ".cnt2"}, {2'b00, n2}, cnt_exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 8'h00; a = 4'h0; b = 4'h0;
    load = 1'b0; load_val = 4'h0; err_clr = 1'b0;
    #12;
    expect_state("reset", 4'b0101, 4'b0101, 4'b0101, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    rst = 1'b0;

    // D mode, then enable low
    mode = 8'h00; en = 1'b1; a = 4'b1100;
    step(); expect_state("d_load", 4'b1100, 4'b1100, 4'b1100, 4'b1001, 4'b1001, 4'b1001, 4'h0, 2'd0);
    en = 1'b0; a = 4'b0011;
    step(); expect_state("d_hold", 4'b1100, 4'b1100, 4'b1100, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);

    // T mode from 0000
    load = 1'b1; load_val = 4'b0000;
    step(); expect_state("ld0", 4'h0, 4'h0, 4'h0, 4'b1100, 4'b1100, 4'b1100, 4'h0, 2'd0);
    load = 1'b0; en = 1'b1; mode = 8'b01010101; a = 4'b1111;
    step(); expect_state("t1", 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0);
    step(); expect_state("t2", 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0);
    step(); expect_state("t3", 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0);

    // Illegal SR on channel 0 (others JK with a=b=0 hold)
    mode = 8'b11111110; a = 4'b0001; b = 4'b0001;
    step(); expect_state("sr_ill", 4'b1111, 4'b1111, 4'b1110, 4'h0, 4'h0, 4'b0001, 4'b0001, 2'd1);
    err_clr = 1'b1;
    step(); expect_state("sr_ill_clr", 4'b1111, 4'b1111, 4'b1110, 4'h0, 4'h0, 4'h0, 4'b0001, 2'd1);
    en = 1'b0;
    step(); expect_state("clr_only", 4'b1111, 4'b1111, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    err_clr = 1'b0; load = 1'b1; load_val = 4'b0000; en = 1'b1;
    step(); expect_state("ld_over_sr", 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'b1110, 4'h0, 2'd0);
    load = 1'b0;
    step(); expect_state("sr_ill_pol", 4'h0, 4'b0001, 4'h0, 4'h0, 4'b0001, 4'h0, 4'b0001, 2'd1);
    err_clr = 1'b1; en = 1'b0;
    step(); expect_state("clr2", 4'h0, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);

    // Counter saturation: illegal on channels 0 and 1 for 5 cycles
    err_clr = 1'b0; en = 1'b1; mode = 8'b11111010; a = 4'b0011; b = 4'b0011;
    step(); expect_state("cnt1", 4'h0, 4'b0011, 4'h0, 4'h0, 4'b0010, 4'h0, 4'b0011, 2'd1);
    step(); expect_state("cnt2", 4'h0, 4'b0011, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0011, 2'd2);
    step(); expect_state("cnt3", 4'h0, 4'b0011, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0011, 2'd3);
    step(); expect_state("cnt4", 4'h0, 4'b0011, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0011, 2'd3);
    step(); expect_state("cnt5", 4'h0, 4'b0011, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0011, 2'd3);
    err_clr = 1'b1;
    step(); expect_state("cnt_clr_evt", 4'h0, 4'b0011, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0011, 2'd1);

    // JK toggle, then load beats JK
    load = 1'b1; load_val = 4'b0101; en = 1'b0;
    step(); expect_state("ld5", 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0110, 4'b0101, 4'h0, 2'd0);
    err_clr = 1'b0; load = 1'b0; en = 1'b1; mode = 8'hFF; a = 4'hF; b = 4'hF;
    step(); expect_state("jk1", 4'b1010, 4'b1010, 4'b1010, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0);
    step(); expect_state("jk2", 4'b0101, 4'b0101, 4'b0101, 4'hF, 4'hF, 4'hF, 4'h0, 2'd0);
    load = 1'b1; load_val = 4'b0011;
    step(); expect_state("jk_ld", 4'b0011, 4'b0011, 4'b0011, 4'b0110, 4'b0110, 4'b0110, 4'h0, 2'd0);

    // Mid-cycle asynchronous reset with q=1010 and a flagged error
    load_val = 4'b1010;
    step(); expect_state("ld_a", 4'b1010, 4'b1010, 4'b1010, 4'b1001, 4'b1001, 4'b1001, 4'h0, 2'd0);
    load = 1'b0; mode = 8'b11111110; a = 4'b0001; b = 4'b0001;
    step(); expect_state("pre_rst", 4'b1010, 4'b1011, 4'b1010, 4'h0, 4'b0001, 4'h0, 4'b0001, 2'd1);
    #3 rst = 1'b1;
    #1 expect_state("async_rst", 4'b0101, 4'b0101, 4'b0101, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    en = 1'b0;
    #2 rst = 1'b0;
    step(); expect_state("post_rst_hold", 4'b0101, 4'b0101, 4'b0101, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    en = 1'b1; mode = 8'h00; a = 4'b0110;
    step(); expect_state("post_rst_d", 4'b0110, 4'b0110, 4'b0110, 4'b0011, 4'b0011, 4'b0011, 4'h0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
